// File: rtl/ahb_frame_mem.sv
// AHB-Lite slave frame memory: word-organised RAM with little-endian byte lanes,
// programmable wait states and a two-cycle ERROR response.
module ahb_frame_mem #(
  parameter int          DEPTH       = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic        I_HCLK,
  input  logic        I_HRESET,
  input  logic        I_HSEL,
  input  logic [31:0] I_HADDR,
  input  logic [1:0]  I_HTRANS,
  input  logic        I_HWRITE,
  input  logic [2:0]  I_HSIZE,
  input  logic [3:0]  I_HBURST,
  input  logic [31:0] I_HWDATA,
  input  logic        I_HREADY,
  output logic [31:0] O_HRDATA,
  output logic        O_HREADY,
  output logic [1:0]  O_HRESP,
  output logic [2:0]  dbg_state
);

  localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] SPAN      = 33'(DEPTH) << 2;
  localparam logic [3:0]  WAIT_LAST = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);
  localparam logic [1:0]  RESP_OKAY = 2'b00;
  localparam logic [1:0]  RESP_ERR  = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_XFER = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      wait_cnt_q;
  logic [AW-1:0]   word_q;
  logic [3:0]      be_q;
  logic            write_q;
  logic [31:0]     rdata_q;
  logic [31:0]     mem [DEPTH];

  logic [31:0]     offset;
  logic [AW-1:0]   acc_word;
  logic            accept;
  logic            acc_err;
  logic [31:0]     mem_word;
  logic [31:0]     fwd_word;
  logic            unused_bits;

  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] lane);
    logic [3:0] m;
    m = 4'b1111;
    if (size == 3'b000)      m = 4'b0001 << lane;
    else if (size == 3'b001) m = lane[1] ? 4'b1100 : 4'b0011;
    return m;
  endfunction

  // Address phase handshake: a transfer is taken on an edge where the slave is
  // selected, the bus HREADY is high, the slave itself is ready and HTRANS is
  // NONSEQ/SEQ. The data phase ends on the first cycle with O_HREADY high.
  assign offset   = I_HADDR - BASE_ADDR;
  assign acc_word = offset[AW+1:2];
  assign accept   = I_HSEL & I_HREADY & O_HREADY & I_HTRANS[1];
  assign acc_err  = ({1'b0, offset} >= SPAN) ||
                    (I_HSIZE > 3'b010) ||
                    ((I_HSIZE == 3'b001) && offset[0]) ||
                    ((I_HSIZE == 3'b010) && (offset[1:0] != 2'b00));

  assign O_HREADY    = !((state_q == S_WAIT) || (state_q == S_ERR1));
  assign O_HRESP     = ((state_q == S_ERR1) || (state_q == S_ERR2)) ? RESP_ERR : RESP_OKAY;
  assign O_HRDATA    = rdata_q;
  assign dbg_state   = state_q;
  assign unused_bits = ^{I_HBURST, I_HTRANS[0]};

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_XFER, S_ERR2: begin
        if (!accept)      state_d = S_IDLE;
        else if (acc_err) state_d = S_ERR1;
        else              state_d = (WAIT_STATES > 0) ? S_WAIT : S_XFER;
      end
      S_WAIT:  if (wait_cnt_q == WAIT_LAST) state_d = S_XFER;
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
  end

  // The read word is captured at accept; a write completing on that same edge
  // to the same word is merged in so back-to-back write/read sees new data.
  always_comb begin
    mem_word = mem[acc_word];
    fwd_word = mem_word;
    if ((state_q == S_XFER) && write_q && (word_q == acc_word)) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) fwd_word[8*b +: 8] = I_HWDATA[8*b +: 8];
      end
    end
  end

  always_ff @(posedge I_HCLK) begin
    if (I_HRESET) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= 4'd0;
      word_q     <= '0;
      be_q       <= 4'b0000;
      write_q    <= 1'b0;
      rdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= (state_q == S_WAIT) ? (wait_cnt_q + 4'd1) : 4'd0;
      if (accept) begin
        word_q  <= acc_word;
        be_q    <= lane_mask(I_HSIZE, offset[1:0]);
        write_q <= I_HWRITE & ~acc_err;
        if (!I_HWRITE && !acc_err) rdata_q <= fwd_word;
      end
    end
  end

  // Storage is never reset; a reset edge also cancels a write in its XFER cycle.
  always_ff @(posedge I_HCLK) begin
    if (!I_HRESET && (state_q == S_XFER) && write_q) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) mem[word_q][8*b +: 8] <= I_HWDATA[8*b +: 8];
      end
    end
  end

endmodule
